xgmii_frame_generator: RTL and testbench
========================================

XGMII_FRAME_GENERATOR -- requirements
Module: xgmii_frame_generator

Interface
- REQ-001 Parameter DATA_WIDTH, default 64, meaning datapath width in bits; legal values 32 or 64; LANES = DATA_WIDTH/8.
- REQ-002 Parameter MIN_PAYLOAD, default 46, meaning smallest payload byte count emitted; shorter requests are padded up to this value.
- REQ-003 Parameter MAX_PAYLOAD, default 1500, meaning largest payload byte count emitted; longer requests are clamped to this value.
- REQ-004 Parameters IDLE_CODE 8'h07, START_CODE 8'hFB, TERM_CODE 8'hFD, ERROR_CODE 8'hFE, meaning XGMII control characters.
- REQ-005 tx_clk  input  1  single clock; all logic on its rising edge.
- REQ-006 i_rst  input  1  reset, asynchronous, active-high.
- REQ-007 i_start  input  1  frame request; sampled only in IDLE.
- REQ-008 i_payload_len  input  11  payload byte count; latched on accepted start.
- REQ-009 i_ipg_words  input  4  idle words after the terminate word; latched on accepted start; 0 treated as 1.
- REQ-010 i_pattern_sel  input  1  0 = incrementing bytes, 1 = fixed 8'hAA; latched on accepted start.
- REQ-011 i_inject_err  input  1  error-injection request; latched on accepted start.
- REQ-012 o_txd  output  DATA_WIDTH  lane n = bits [8n+7:8n]; lane 0 transmitted first.
- REQ-013 o_txc  output  LANES  bit n = 1 marks lane n as a control character.
- REQ-014 o_busy  output  1  high from the cycle after an accepted start until the FSM returns to IDLE.
- REQ-015 o_frame_done  output  1  one-cycle pulse coincident with the word carrying TERM_CODE.
- REQ-016 o_frame_cnt  output  16  count of completed frames; wraps 16'hFFFF -> 0.

Function
- REQ-017 FSM states SHALL be IDLE, PREAMBLE, DATA, TERM, IPG; all outputs registered.
- REQ-018 IDLE: o_txd = all lanes IDLE_CODE, o_txc = all ones; i_start = 1 -> PREAMBLE; first preamble word on outputs the next cycle.
- REQ-019 Preamble byte stream SHALL be FB,55,55,55,55,55,55,D5 with only the FB lane flagged in o_txc; 1 word at 64 bits, 2 words at 32 bits.
- REQ-020 DATA: payload byte k (k from 0) = k mod 256 when pattern 0, 8'hAA when pattern 1; o_txc lane bits 0 for data lanes.
- REQ-021 Effective length L = clamp(i_payload_len, MIN_PAYLOAD, MAX_PAYLOAD).
- REQ-022 Last data word: if L mod LANES != 0, TERM_CODE goes in lane (L mod LANES), later lanes IDLE_CODE, all those lanes flagged; this word is the TERM word.
- REQ-023 If L mod LANES = 0, an extra TERM word follows: lane 0 TERM_CODE, other lanes IDLE_CODE, o_txc all ones.
- REQ-024 IPG: emit latched i_ipg_words idle words (min 1), then IDLE; o_busy low in IDLE.
- REQ-025 i_start while o_busy = 1 SHALL be ignored; no queuing.
- REQ-026 o_frame_cnt SHALL increment in the cycle o_frame_done is high.
- REQ-027 Changes to latched inputs during a frame SHALL not affect that frame.

Reset
- REQ-028 On i_rst assertion, immediately and regardless of clock: state IDLE, o_txd all lanes IDLE_CODE, o_txc all ones, o_busy 0, o_frame_done 0, o_frame_cnt 0, internal counters 0.
- REQ-029 Reset mid-frame SHALL abort the frame with no TERM word and no count increment; first start after release is handled normally.

Configuration
- REQ-030 With XGMII_GEN_ERR_INJ_EN defined, a frame started with i_inject_err = 1 SHALL have lane 0 of its first data word replaced by ERROR_CODE with that o_txc bit 1; other bytes unchanged.
- REQ-031 With XGMII_GEN_ERR_INJ_EN undefined, i_inject_err SHALL be ignored and no ERROR_CODE ever emitted; port remains present.

Verification (DATA_WIDTH=64)
- REQ-032 Reset then idle -> o_txd = 64'h0707070707070707, o_txc = 8'hFF, o_busy = 0.
- REQ-033 start, len 46, pattern 0, ipg 1 -> word1 64'hD5555555555555FB txc 8'h01; words 2-6 data 0x00..0x27; word7 64'h07FD2D2C2B2A2928 txc 8'hC0 with o_frame_done; 1 idle word; o_frame_cnt = 1.
- REQ-034 start, len 48 -> six full data words, then 64'h07070707070707FD txc 8'hFF with o_frame_done.
- REQ-035 start, len 10, pattern 1 -> padded to 46 bytes of 8'hAA; TERM in lane 6.
- REQ-036 Second i_start pulsed during DATA -> ignored; exactly one frame and one o_frame_done.
- REQ-037 i_rst asserted mid-DATA -> outputs idle immediately, o_frame_cnt 0; with XGMII_GEN_ERR_INJ_EN and i_inject_err=1 next frame's word2 lane 0 = 8'hFE, txc 8'h01.

Source files
------------

// File: rtl/xgmii_frame_generator.sv
// XGMII test-frame generator: preamble, patterned payload, terminate and inter-packet gap.
// Optional error injection on the first data byte is enabled by defining XGMII_GEN_ERR_INJ_EN.
module xgmii_frame_generator #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter logic [7:0]  IDLE_CODE   = 8'h07,
    parameter logic [7:0]  START_CODE  = 8'hFB,
    parameter logic [7:0]  TERM_CODE   = 8'hFD,
    parameter logic [7:0]  ERROR_CODE  = 8'hFE
) (
    input  logic                      tx_clk,
    input  logic                      i_rst,
    input  logic                      i_start,
    input  logic [10:0]               i_payload_len,
    input  logic [3:0]                i_ipg_words,
    input  logic                      i_pattern_sel,
    input  logic                      i_inject_err,
    output logic [DATA_WIDTH-1:0]     o_txd,
    output logic [DATA_WIDTH/8-1:0]   o_txc,
    output logic                      o_busy,
    output logic                      o_frame_done,
    output logic [15:0]               o_frame_cnt
);

    localparam int                    LANES     = DATA_WIDTH / 8;
    localparam int                    PRE_WORDS = 8 / LANES;
    localparam logic [1:0]            PRE_W     = 2'(PRE_WORDS);
    localparam logic [10:0]           LANES_W   = 11'(LANES);
    localparam logic [10:0]           MIN_W     = 11'(MIN_PAYLOAD);
    localparam logic [10:0]           MAX_W     = 11'(MAX_PAYLOAD);
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {LANES{IDLE_CODE}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_TERM,
        ST_IPG
    } state_t;

    // state_q names the word currently presented on o_txd/o_txc
    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   txd_q, txd_d;
    logic [LANES-1:0]        txc_q, txc_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [15:0]             frame_cnt_q, frame_cnt_d;
    logic [10:0]             byte_cnt_q, byte_cnt_d;
    logic [10:0]             len_q, len_d;
    logic [3:0]              ipg_cnt_q, ipg_cnt_d;
    logic                    pat_q, pat_d;
    logic                    inj_q, inj_d;
    logic [1:0]              pre_idx_q, pre_idx_d;

    logic [10:0]             len_clamped;
    logic [10:0]             remain;
    logic                    data_is_term;
    logic [DATA_WIDTH-1:0]   data_txd;
    logic [LANES-1:0]        data_txc;

    function automatic logic [LANES+DATA_WIDTH-1:0] preamble_word(input logic [1:0] w);
        logic [DATA_WIDTH-1:0] d;
        logic [LANES-1:0]      c;
        int                    j;
        d = '0;
        c = '0;
        for (int i = 0; i < LANES; i++) begin
            j = int'(w) * LANES + i;
            if (j == 0) begin
                d[8*i +: 8] = START_CODE;
                c[i]        = 1'b1;
            end else if (j == 7) begin
                d[8*i +: 8] = 8'hD5;
            end else begin
                d[8*i +: 8] = 8'h55;
            end
        end
        return {c, d};
    endfunction

    always_comb begin
        if (i_payload_len < MIN_W) begin
            len_clamped = MIN_W;
        end else if (i_payload_len > MAX_W) begin
            len_clamped = MAX_W;
        end else begin
            len_clamped = i_payload_len;
        end
    end

    // Next data word starting at byte_cnt_q; becomes the TERM word when fewer than LANES bytes remain
    always_comb begin
        remain       = len_q - byte_cnt_q;
        data_is_term = (remain < LANES_W);
        data_txd     = '0;
        data_txc     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!data_is_term || (11'(i) < remain)) begin
                data_txd[8*i +: 8] = pat_q ? 8'hAA : 8'(byte_cnt_q + 11'(i));
            end else if (11'(i) == remain) begin
                data_txd[8*i +: 8] = TERM_CODE;
                data_txc[i]        = 1'b1;
            end else begin
                data_txd[8*i +: 8] = IDLE_CODE;
                data_txc[i]        = 1'b1;
            end
        end
`ifdef XGMII_GEN_ERR_INJ_EN
        if (inj_q && (byte_cnt_q == '0)) begin
            data_txd[7:0] = ERROR_CODE;
            data_txc[0]   = 1'b1;
        end
`endif
    end

`ifndef XGMII_GEN_ERR_INJ_EN
    logic unused_inj;
    assign unused_inj = inj_q ^ (|ERROR_CODE);
`endif

    always_comb begin
        state_d     = state_q;
        txd_d       = IDLE_WORD;
        txc_d       = '1;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        len_d       = len_q;
        ipg_cnt_d   = ipg_cnt_q;
        pat_d       = pat_q;
        inj_d       = inj_q;
        pre_idx_d   = pre_idx_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (i_start) begin
                    state_d        = ST_PREAMBLE;
                    busy_d         = 1'b1;
                    len_d          = len_clamped;
                    ipg_cnt_d      = (i_ipg_words == 4'd0) ? 4'd0 : (i_ipg_words - 4'd1);
                    pat_d          = i_pattern_sel;
                    inj_d          = i_inject_err;
                    byte_cnt_d     = '0;
                    pre_idx_d      = 2'd1;
                    {txc_d, txd_d} = preamble_word(2'd0);
                end
            end

            ST_PREAMBLE, ST_DATA: begin
                if ((state_q == ST_PREAMBLE) && (pre_idx_q != PRE_W)) begin
                    {txc_d, txd_d} = preamble_word(pre_idx_q);
                    pre_idx_d      = pre_idx_q + 2'd1;
                end else begin
                    txd_d = data_txd;
                    txc_d = data_txc;
                    if (data_is_term) begin
                        state_d     = ST_TERM;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    end else begin
                        state_d    = ST_DATA;
                        byte_cnt_d = byte_cnt_q + LANES_W;
                    end
                end
            end

            ST_TERM: begin
                state_d = ST_IPG;
            end

            ST_IPG: begin
                if (ipg_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    ipg_cnt_d = ipg_cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge tx_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            txd_q       <= IDLE_WORD;
            txc_q       <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            byte_cnt_q  <= '0;
            len_q       <= '0;
            ipg_cnt_q   <= '0;
            pat_q       <= 1'b0;
            inj_q       <= 1'b0;
            pre_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            txd_q       <= txd_d;
            txc_q       <= txc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            len_q       <= len_d;
            ipg_cnt_q   <= ipg_cnt_d;
            pat_q       <= pat_d;
            inj_q       <= inj_d;
            pre_idx_q   <= pre_idx_d;
        end
    end

    assign o_txd        = txd_q;
    assign o_txc        = txc_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_xgmii_frame_generator.sv
// Directed bench for xgmii_frame_generator at DATA_WIDTH = 64.
// Error-injection expectations follow XGMII_GEN_ERR_INJ_EN.
module tb_xgmii_frame_generator;

    logic        tx_clk;
    logic        i_rst;
    logic        i_start;
    logic [10:0] i_payload_len;
    logic [3:0]  i_ipg_words;
    logic        i_pattern_sel;
    logic        i_inject_err;
    logic [63:0] o_txd;
    logic [7:0]  o_txc;
    logic        o_busy;
    logic        o_frame_done;
    logic [15:0] o_frame_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;

    xgmii_frame_generator dut (
        .tx_clk        (tx_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_payload_len (i_payload_len),
        .i_ipg_words   (i_ipg_words),
        .i_pattern_sel (i_pattern_sel),
        .i_inject_err  (i_inject_err),
        .o_txd         (o_txd),
        .o_txc         (o_txc),
        .o_busy        (o_busy),
        .o_frame_done  (o_frame_done),
        .o_frame_cnt   (o_frame_cnt)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    function automatic logic [63:0] inc_word(input int base);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'((base + i) % 256);
        return w;
    endfunction

    task automatic start_frame(input int len, input int ipg, input logic pat, input logic inj);
        i_start       = 1'b1;
        i_payload_len = 11'(len);
        i_ipg_words   = 4'(ipg);
        i_pattern_sel = pat;
        i_inject_err  = inj;
        tick();
        i_start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [63:0] exp_d;
        logic [63:0] exp_c;

        i_rst = 1'b1; i_start = 1'b0; i_payload_len = '0; i_ipg_words = '0;
        i_pattern_sel = 1'b0; i_inject_err = 1'b0;
        repeat (2) tick();
        check("rst_txd",  o_txd, IDLE_W);
        check("rst_txc",  64'(o_txc), 64'hFF);
        check("rst_busy", 64'(o_busy), 64'd0);
        check("rst_cnt",  64'(o_frame_cnt), 64'd0);
        i_rst = 1'b0;
        tick();
        check("idle_txd",  o_txd, IDLE_W);
        check("idle_txc",  64'(o_txc), 64'hFF);
        check("idle_busy", 64'(o_busy), 64'd0);

        // Frame 1: len 46, incrementing, ipg 1; latched inputs disturbed mid-frame
        start_frame(46, 1, 1'b0, 1'b0);
        i_payload_len = 11'd200; i_pattern_sel = 1'b1; i_ipg_words = 4'd9;
        check("f1_pre_txd", o_txd, PRE_W);
        check("f1_pre_txc", 64'(o_txc), 64'h01);
        check("f1_busy",    64'(o_busy), 64'd1);
        for (int w = 0; w < 5; w++) begin
            tick();
            check("f1_data_txd", o_txd, inc_word(8 * w));
            check("f1_data_txc", 64'(o_txc), 64'h00);
            check("f1_data_done", 64'(o_frame_done), 64'd0);
        end
        tick();
        check("f1_term_txd", o_txd, 64'h07FD2D2C2B2A2928);
        check("f1_term_txc", 64'(o_txc), 64'hC0);
        check("f1_done",     64'(o_frame_done), 64'd1);
        check("f1_cnt",      64'(o_frame_cnt), 64'd1);
        tick();
        check("f1_ipg_txd",  o_txd, IDLE_W);
        check("f1_ipg_busy", 64'(o_busy), 64'd1);
        check("f1_ipg_done", 64'(o_frame_done), 64'd0);
        tick();
        check("f1_end_busy", 64'(o_busy), 64'd0);
        check("f1_end_cnt",  64'(o_frame_cnt), 64'd1);

        // Frame 2: len 48 (multiple of 8), ipg 3, extra start pulse in DATA
        start_frame(48, 3, 1'b0, 1'b0);
        check("f2_pre_txd", o_txd, PRE_W);
        for (int w = 0; w < 6; w++) begin
            tick();
            check("f2_data_txd", o_txd, inc_word(8 * w));
            check("f2_data_txc", 64'(o_txc), 64'h00);
            if (w == 1) i_start = 1'b1;
            if (w == 2) i_start = 1'b0;
        end
        tick();
        check("f2_term_txd", o_txd, 64'h07070707070707FD);
        check("f2_term_txc", 64'(o_txc), 64'hFF);
        check("f2_done",     64'(o_frame_done), 64'd1);
        check("f2_cnt",      64'(o_frame_cnt), 64'd2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("f2_ipg_txd",  o_txd, IDLE_W);
            check("f2_ipg_busy", 64'(o_busy), 64'd1);
        end
        tick();
        check("f2_end_busy", 64'(o_busy), 64'd0);
        repeat (4) tick();
        check("f2_no_restart_busy", 64'(o_busy), 64'd0);
        check("f2_no_restart_cnt",  64'(o_frame_cnt), 64'd2);

        // Frame 3: len 10 padded to 46, fixed AA, ipg 0 behaves as 1
        start_frame(10, 0, 1'b1, 1'b0);
        check("f3_pre_txd", o_txd, PRE_W);
        for (int w = 0; w < 5; w++) begin
            tick();
            check("f3_data_txd", o_txd, 64'hAAAAAAAAAAAAAAAA);
        end
        tick();
        check("f3_term_txd", o_txd, 64'h07FDAAAAAAAAAAAA);
        check("f3_term_txc", 64'(o_txc), 64'hC0);
        check("f3_done",     64'(o_frame_done), 64'd1);
        check("f3_cnt",      64'(o_frame_cnt), 64'd3);
        tick();
        check("f3_ipg_busy", 64'(o_busy), 64'd1);
        tick();
        check("f3_end_busy", 64'(o_busy), 64'd0);

        // Frame 4: len 2000 clamped to 1500 -> 187 full words, TERM in lane 4
        start_frame(2000, 2, 1'b0, 1'b0);
        n = 0;
        tick();
        while (!o_frame_done && n < 400) begin
            n++;
            tick();
        end
        check("f4_done_seen",  64'(o_frame_done), 64'd1);
        check("f4_data_words", 64'(n), 64'd187);
        check("f4_term_txd",   o_txd, 64'h070707FDDBDAD9D8);
        check("f4_term_txc",   64'(o_txc), 64'hF0);
        check("f4_cnt",        64'(o_frame_cnt), 64'd4);
        repeat (2) tick();
        check("f4_ipg_busy", 64'(o_busy), 64'd1);
        tick();
        check("f4_end_busy", 64'(o_busy), 64'd0);

        // Reset asserted mid-DATA, checked before the next clock edge
        start_frame(46, 1, 1'b0, 1'b0);
        repeat (2) tick();
        #2;
        i_rst = 1'b1;
        #1;
        check("mrst_txd",  o_txd, IDLE_W);
        check("mrst_txc",  64'(o_txc), 64'hFF);
        check("mrst_busy", 64'(o_busy), 64'd0);
        check("mrst_done", 64'(o_frame_done), 64'd0);
        check("mrst_cnt",  64'(o_frame_cnt), 64'd0);
        i_rst = 1'b0;
        tick();
        check("mrst_idle_txd", o_txd, IDLE_W);

        // Frame 5: first frame after reset, error injection requested
        start_frame(46, 1, 1'b0, 1'b1);
        check("f5_pre_txd", o_txd, PRE_W);
        tick();
        exp_d = inc_word(0);
        exp_c = 64'h00;
`ifdef XGMII_GEN_ERR_INJ_EN
        exp_d[7:0] = 8'hFE;
        exp_c      = 64'h01;
`endif
        check("f5_word2_txd", o_txd, exp_d);
        check("f5_word2_txc", 64'(o_txc), exp_c);
        for (int w = 1; w < 5; w++) begin
            tick();
            check("f5_data_txd", o_txd, inc_word(8 * w));
            check("f5_data_txc", 64'(o_txc), 64'h00);
        end
        tick();
        check("f5_term_txd", o_txd, 64'h07FD2D2C2B2A2928);
        check("f5_done",     64'(o_frame_done), 64'd1);
        check("f5_cnt",      64'(o_frame_cnt), 64'd1);
        repeat (2) tick();
        check("f5_end_busy", 64'(o_busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
